// File: rtl/muldiv_dispatch_if.sv
// muldiv_dispatch shared types and request interface.
// Execute-stage request handshake bundle plus multiplier op codes.
package muldiv_pkg;
  localparam int MUL_OP_WIDTH = 2;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL   = 2'd0;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH  = 2'd1;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULSU = 2'd2;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULU  = 2'd3;
endpackage

interface muldiv_req_if;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        busy;
  logic        req_ready;
  logic [31:0] req_result;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2,
    input  busy, req_ready, req_result
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2,
    output busy, req_ready, req_result
  );
endinterface

// File: rtl/muldiv_dispatch.sv
// muldiv_dispatch: RV32M front end driving mul/div engines.
// Optional one-entry result cache: MULDIV_RESULT_CACHE_EN.
module muldiv_dispatch
  import muldiv_pkg::*;
#(
  parameter int DIV_BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  muldiv_req_if.slave             req,
  output logic                    mul_valid,
  output logic [MUL_OP_WIDTH-1:0] mul_op,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic                    mul_ready,
  input  logic [31:0]             mul_result,
  output logic                    div_valid,
  output logic [1:0]              div_op,
  output logic [31:0]             div_a,
  output logic [31:0]             div_b,
  input  logic                    div_ready,
  input  logic [31:0]             div_result
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    DECODE  = 4'b0010,
    ISSUE   = 4'b0100,
    RELEASE = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  f3_q;
  logic [31:0] a_q, b_q, cap_q;
  logic        lat, go_mul, go_div, cap, done;
  logic [31:0] done_val;
  logic        eng_ready;
  logic [31:0] eng_res;
  logic        byp;
  logic [31:0] byp_val;
  logic        hit;
  logic [31:0] hit_val;
  logic [MUL_OP_WIDTH-1:0] mop;

  assign req.busy  = (state_q != IDLE);
  assign eng_ready = f3_q[2] ? div_ready : mul_ready;
  assign eng_res   = f3_q[2] ? div_result : mul_result;

  // Map funct3 low bits onto the multiplier op code
  always_comb begin
    mop = MUL_OP_MUL;
    unique case (f3_q[1:0])
      2'd0: mop = MUL_OP_MUL;
      2'd1: mop = MUL_OP_MULH;
      2'd2: mop = MUL_OP_MULSU;
      2'd3: mop = MUL_OP_MULU;
    endcase
  end

  // Resolve divide-by-zero and signed overflow without the divider
  always_comb begin
    byp     = 1'b0;
    byp_val = '0;
    if (DIV_BYPASS != 0 && f3_q[2]) begin
      if (b_q == '0) begin
        byp     = 1'b1;
        byp_val = f3_q[1] ? a_q : '1;
      end else if (!f3_q[0] && a_q == 32'h8000_0000
                   && b_q == '1) begin
        byp     = 1'b1;
        byp_val = f3_q[1] ? '0 : 32'h8000_0000;
      end
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic        c_vld;
  logic [2:0]  c_f3;
  logic [31:0] c_a, c_b, c_res;

  assign hit = c_vld && c_f3 == f3_q
            && c_a == a_q && c_b == b_q;
  assign hit_val = c_res;

  // Refill the single entry on every completion
  always_ff @(posedge clk) begin
    if (!resetn) begin
      c_vld <= 1'b0;
      c_f3  <= '0;
      c_a   <= '0;
      c_b   <= '0;
      c_res <= '0;
    end else if (done) begin
      c_vld <= 1'b1;
      c_f3  <= f3_q;
      c_a   <= a_q;
      c_b   <= b_q;
      c_res <= done_val;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_val = '0;
`endif

  // Next state and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    lat      = 1'b0;
    go_mul   = 1'b0;
    go_div   = 1'b0;
    cap      = 1'b0;
    done     = 1'b0;
    done_val = cap_q;
    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          lat     = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (hit) begin
          done     = 1'b1;
          done_val = hit_val;
          state_d  = IDLE;
        end else if (byp) begin
          done     = 1'b1;
          done_val = byp_val;
          state_d  = IDLE;
        end else if (f3_q[2]) begin
          go_div  = 1'b1;
          state_d = ISSUE;
        end else begin
          go_mul  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (eng_ready) begin
          cap     = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!eng_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, engine ports and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      f3_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      cap_q          <= '0;
      req.req_ready  <= 1'b0;
      req.req_result <= '0;
      mul_valid      <= 1'b0;
      mul_op         <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      div_valid      <= 1'b0;
      div_op         <= '0;
      div_a          <= '0;
      div_b          <= '0;
    end else begin
      state_q       <= state_d;
      req.req_ready <= done;
      if (done) req.req_result <= done_val;
      if (lat) begin
        f3_q <= req.req_funct3;
        a_q  <= req.req_rs1;
        b_q  <= req.req_rs2;
      end
      if (go_mul) begin
        mul_valid <= 1'b1;
        mul_op    <= mop;
        mul_a     <= a_q;
        mul_b     <= b_q;
      end
      if (go_div) begin
        div_valid <= 1'b1;
        div_op    <= f3_q[1:0];
        div_a     <= a_q;
        div_b     <= b_q;
      end
      if (cap) begin
        cap_q     <= eng_res;
        mul_valid <= 1'b0;
        div_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_dispatch.sv
// tb_muldiv_dispatch: random RV32M requests vs arithmetic model.
// Engines modelled with random latency and release delay.
module tb_muldiv_dispatch;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  muldiv_req_if rq();

  logic                    mul_valid;
  logic [MUL_OP_WIDTH-1:0] mul_op;
  logic [31:0]             mul_a, mul_b;
  logic                    mul_ready;
  logic [31:0]             mul_result;
  logic                    div_valid;
  logic [1:0]              div_op;
  logic [31:0]             div_a, div_b;
  logic                    div_ready;
  logic [31:0]             div_result;

  muldiv_dispatch dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (rq),
    .mul_valid  (mul_valid),
    .mul_op     (mul_op),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ready  (mul_ready),
    .mul_result (mul_result),
    .div_valid  (div_valid),
    .div_op     (div_op),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = int'(a);
    sb = int'(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = int'(a);
    ib = int'(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] mul_model(
    input logic [MUL_OP_WIDTH-1:0] op,
    input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = {{32{a[31] & (op == MUL_OP_MULH || op == MUL_OP_MULSU)}}, a};
    xb = {{32{b[31] & (op == MUL_OP_MULH)}}, b};
    p  = xa * xb;
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [MUL_OP_WIDTH-1:0] exp_mop(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return MUL_OP_MUL;
      2'd1: return MUL_OP_MULH;
      2'd2: return MUL_OP_MULSU;
      default: return MUL_OP_MULU;
    endcase
  endfunction

  int eng_lat = 0;
  int mcnt = 0;
  int dcnt = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      mul_ready  <= 1'b0;
      mul_result <= '0;
      mcnt       <= 0;
    end else if (mul_valid && !mul_ready) begin
      if (mcnt >= eng_lat) begin
        mul_ready  <= 1'b1;
        mul_result <= mul_model(mul_op, mul_a, mul_b);
        mcnt       <= 0;
      end else mcnt <= mcnt + 1;
    end else if (mul_ready && !mul_valid && $urandom_range(0, 1) == 1) begin
      mul_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      div_ready  <= 1'b0;
      div_result <= '0;
      dcnt       <= 0;
    end else if (div_valid && !div_ready) begin
      if (dcnt >= eng_lat) begin
        div_ready  <= 1'b1;
        div_result <= ref_result({1'b1, div_op}, div_a, div_b);
        dcnt       <= 0;
      end else dcnt <= dcnt + 1;
    end else if (div_ready && !div_valid && $urandom_range(0, 1) == 1) begin
      div_ready <= 1'b0;
    end
  end

  int mul_issues = 0;
  int div_issues = 0;
  logic mv_q = 1'b0, mr_q = 1'b0, dv_q = 1'b0, dr_q = 1'b0;
  logic [MUL_OP_WIDTH-1:0] iss_mop;
  logic [1:0] iss_dop;
  logic [31:0] iss_a, iss_b;
  bit rst_test = 1'b0;

  always @(negedge clk) begin
    if (mul_valid && !mv_q) begin
      mul_issues++;
      iss_mop = mul_op;
      iss_a   = mul_a;
      iss_b   = mul_b;
    end
    if (div_valid && !dv_q) begin
      div_issues++;
      iss_dop = div_op;
      iss_a   = div_a;
      iss_b   = div_b;
    end
    if (mv_q && !mul_valid && !rst_test) chk("mul_hold", mr_q, 1);
    if (dv_q && !div_valid && !rst_test) chk("div_hold", dr_q, 1);
    mv_q = mul_valid;
    mr_q = mul_ready;
    dv_q = div_valid;
    dr_q = div_ready;
  end

  bit c_vld = 1'b0;
  logic [2:0] c_f3;
  logic [31:0] c_a, c_b;

  function automatic bit uses_engine(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_RESULT_CACHE_EN
    if (c_vld && c_f3 == f3 && c_a == a && c_b == b) return 1'b0;
`endif
    if (f3[2] && b == 0) return 1'b0;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_req(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit noise,
                        output logic [31:0] res);
    logic [31:0] exp;
    bit eng, done;
    int m0, d0, cyc;
    exp = ref_result(f3, a, b);
    eng = uses_engine(f3, a, b);
    m0  = mul_issues;
    d0  = div_issues;
    eng_lat = $urandom_range(0, 3);
    rq.req_valid  = 1'b1;
    rq.req_funct3 = f3;
    rq.req_rs1    = a;
    rq.req_rs2    = b;
    @(negedge clk);
    rq.req_valid = 1'b0;
    rq.req_rs1   = $urandom;
    rq.req_rs2   = $urandom;
    chk("accept", {rq.busy, rq.req_ready}, 2'b10);
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 200) begin
      rq.req_valid = noise && cyc == 2 && rq.busy;
      if (rq.req_valid) begin
        rq.req_funct3 = 3'($urandom);
        rq.req_rs1    = $urandom;
        rq.req_rs2    = $urandom;
      end
      @(negedge clk);
      cyc++;
      done = rq.req_ready;
    end
    rq.req_valid = 1'b0;
    res = rq.req_result;
    if (!done) chk("timeout", 0, 1);
    chk("result", rq.req_result, exp);
    chk("busy_done", rq.busy, 0);
    if (!eng) chk("fast_lat", cyc, 2);
    else if (cyc < 4) chk("eng_lat", cyc, 4);
    chk("mul_iss", mul_issues - m0, (eng && !f3[2]) ? 1 : 0);
    chk("div_iss", div_issues - d0, (eng && f3[2]) ? 1 : 0);
    if (eng) begin
      if (f3[2]) chk("div_op", iss_dop, f3[1:0]);
      else chk("mul_op", iss_mop, exp_mop(f3));
      chk("eng_a", iss_a, a);
      chk("eng_b", iss_b, b);
    end
    c_vld = 1'b1;
    c_f3  = f3;
    c_a   = a;
    c_b   = b;
  endtask

  logic [31:0] r;
  logic [2:0] pf3;
  logic [31:0] pa, pb;

  initial begin
    int k;
    rq.req_valid  = 1'b0;
    rq.req_funct3 = '0;
    rq.req_rs1    = '0;
    rq.req_rs2    = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", rq.busy, 0);
    chk("rst_ready", rq.req_ready, 0);
    chk("rst_valids", {mul_valid, div_valid}, 0);
    chk("rst_result", rq.req_result, 0);
    chk("rst_ops", {mul_op, div_op}, 0);
    chk("rst_mul_opnd", {mul_a, mul_b}, 0);
    chk("rst_div_opnd", {div_a, div_b}, 0);
    resetn = 1'b1;
    @(negedge clk);

    do_req(3'd0, 32'd7, 32'd6, 1'b0, r);
    chk("mul_42", r, 42);
    do_req(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r);
    chk("mulh_m1", r, 0);
    do_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r);
    chk("mulhu_m1", r, 32'hFFFF_FFFE);
    do_req(3'd4, 32'd100, 32'd0, 1'b0, r);
    chk("div_by0", r, 32'hFFFF_FFFF);
    do_req(3'd7, 32'd100, 32'd0, 1'b0, r);
    chk("remu_by0", r, 100);
    do_req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
    chk("div_ovf", r, 32'h8000_0000);
    do_req(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
    chk("rem_ovf", r, 0);
    do_req(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
    chk("divu_big", r, 0);
    do_req(3'd3, 32'd3, 32'd5, 1'b0, r);
    do_req(3'd3, 32'd3, 32'd5, 1'b0, r);
    chk("mulhu_rep", r, 0);
    do_req(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b1, r);
    chk("mulhsu_neg", r, 32'hFFFF_FFFF);

    rst_test = 1'b1;
    eng_lat = 20;
    rq.req_valid  = 1'b1;
    rq.req_funct3 = 3'd0;
    rq.req_rs1    = 32'd9;
    rq.req_rs2    = 32'd9;
    @(negedge clk);
    rq.req_valid = 1'b0;
    k = 0;
    while (!mul_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!mul_valid) chk("rst_issue_to", 0, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_mulv", mul_valid, 0);
    chk("abort_busy", rq.busy, 0);
    chk("abort_ready", rq.req_ready, 0);
    resetn = 1'b1;
    c_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_test = 1'b0;
    do_req(3'd0, 32'd9, 32'd9, 1'b0, r);
    chk("post_rst", r, 81);

    pf3 = 3'd0;
    pa  = 32'd1;
    pb  = 32'd1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin f3 = pf3; a = pa; b = pb; end
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_req(f3, a, b, $urandom_range(0, 3) == 0, r);
      pf3 = f3;
      pa  = a;
      pb  = b;
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_dispatch.md
Name: muldiv_dispatch

Overview:
Front end of the M-extension datapath. It takes one RV32M request per transaction from the execute stage, decodes funct3, and drives the multiplier (or divider) through the level valid/ready handshake. It handles divide-by-zero and signed overflow locally without starting the divider. It returns one registered 32-bit result with a single-cycle done pulse.

Parameters:
DIV_BYPASS, 1, 1 = resolve div-by-zero and signed-overflow locally; 0 = always issue to the divider.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
req_valid  in  1  start pulse; accepted only while busy=0
req_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_rs1  in  32  operand A / dividend
req_rs2  in  32  operand B / divisor
busy  out  1  high from the cycle after acceptance until the cycle req_ready is high
req_ready  out  1  one-cycle done pulse
req_result  out  32  result; valid while req_ready=1, held until the next completion
mul_valid  out  1  level request to the multiplier
mul_op  out  MUL_OP_WIDTH  MUL_OP_MUL / MUL_OP_MULH / MUL_OP_MULSU / MUL_OP_MULU
mul_a, mul_b  out  32  multiplier operands
mul_ready  in  1  multiplier done level
mul_result  in  32  multiplier result
div_valid  out  1  level request to the divider
div_op  out  2  0 DIV, 1 DIVU, 2 REM, 3 REMU
div_a, div_b  out  32  divider operands
div_ready  in  1  divider done level
div_result  in  32  divider result

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE. busy, req_ready, mul_valid and div_valid are 0. req_result, the operand registers, mul_op and div_op are 0. A reset mid-operation aborts immediately. The engines share resetn, so no handshake cleanup is needed.
- States: one-hot IDLE, DECODE, ISSUE, RELEASE.
- IDLE:
  - req_ready<=0.
  - If req_valid: latch funct3, rs1, rs2; state->DECODE.
- DECODE:
  - funct3[2]=0: load mul_op, mul_a=rs1, mul_b=rs2; mul_valid<=1; state->ISSUE.
  - funct3[2]=1 and DIV_BYPASS with rs2==0: result DIV/DIVU=32'hFFFFFFFF, REM/REMU=rs1. Then req_result<=value, req_ready<=1, state->IDLE.
  - funct3[2]=1 and DIV_BYPASS, signed op, rs1==32'h80000000 and rs2==32'hFFFFFFFF: DIV=32'h80000000, REM=0. Same completion as the previous case.
  - Otherwise: load div_op=funct3[1:0], div_a, div_b; div_valid<=1; state->ISSUE.
- ISSUE:
  - Selected valid stays high.
  - On the selected ready=1: capture the engine result internally, drop valid, state->RELEASE.
  - The unselected engine's ready is ignored.
- RELEASE:
  - Wait for the selected ready=0, which is the engine's return to idle.
  - Then req_result<=captured value, req_ready<=1, state->IDLE.
  - A new request is never issued while the engine still shows ready=1.
- Latency:
  - Bypass path: acceptance edge E0 -> req_ready high after E1.
  - Engine path: engine latency + 3 edges (DECODE, capture, release).
- Back-to-back: req_valid in the req_ready cycle is accepted, because the state is already IDLE.
- req_valid while busy=1 is ignored, with no queueing.
- Operands and op are held stable on the engine ports from DECODE until RELEASE exits.

Optional Feature:
MULDIV_RESULT_CACHE_EN:
- Defined: one entry {valid, funct3, rs1, rs2, result}.
  - Written on every completion, both engine and bypass.
  - In DECODE, a full tag match completes like the bypass path (req_ready after E1) without starting an engine.
  - Entry valid cleared only by reset. The ops are pure functions, so no other invalidation is needed.
- Undefined: no cache storage. Every non-bypass request goes to an engine.

Test Plan:
- MUL rs1=7, rs2=6 -> mul_op=MUL_OP_MUL, mul_valid held until mul_ready; req_result=42 with a one-cycle req_ready after mul_ready falls.
- MULH rs1=32'hFFFFFFFF, rs2=32'hFFFFFFFF -> req_result=0. MULHU with the same operands -> 32'hFFFFFFFE.
- DIV rs1=100, rs2=0 (DIV_BYPASS=1) -> div_valid never rises; req_result=32'hFFFFFFFF, req_ready after E1. REMU rs1=100, rs2=0 -> 100.
- DIV rs1=32'h80000000, rs2=32'hFFFFFFFF -> req_result=32'h80000000, no issue. REM with the same operands -> 0. DIVU with the same operands is issued and returns 0.
- Assert resetn=0 during ISSUE of a MUL -> next edge mul_valid=0, busy=0, req_ready=0; a fresh request afterwards completes correctly.
- Cache: MULHU 3×5 twice with MULDIV_RESULT_CACHE_EN -> second completes after E1 without mul_valid; without the macro, both requests issue to the multiplier.
